// File: rtl/hilo_md_unit_if.sv
// HI/LO unit ALU control codes and the EX-stage bus between the pipeline and hilo_md_unit.
// The package holds the HI/LO-related codes of the ALU control header, including the divide/multiply additions.
package hilo_md_pkg;
    localparam logic [4:0] ALU_MFHI  = 5'd20;
    localparam logic [4:0] ALU_MFLO  = 5'd21;
    localparam logic [4:0] ALU_MTHI  = 5'd22;
    localparam logic [4:0] ALU_MTLO  = 5'd23;
    localparam logic [4:0] ALU_DIV   = 5'd24;
    localparam logic [4:0] ALU_DIVU  = 5'd25;
    localparam logic [4:0] ALU_MULT  = 5'd26;
    localparam logic [4:0] ALU_MULTU = 5'd27;
endpackage

interface hilo_md_unit_if;
    logic [4:0]  alucontrolE;
    logic        validE;
    logic        flushE;
    logic [31:0] srcaE;
    logic [31:0] srcbE;
    logic        stallE;
    logic [31:0] hiloE;
    logic [31:0] hi_o;
    logic [31:0] lo_o;

    // master: the EX stage issuing operations; slave: the HI/LO unit
    modport master (
        output alucontrolE, validE, flushE, srcaE, srcbE,
        input  stallE, hiloE, hi_o, lo_o
    );
    modport slave (
        input  alucontrolE, validE, flushE, srcaE, srcbE,
        output stallE, hiloE, hi_o, lo_o
    );
endinterface

// File: rtl/hilo_md_unit.sv
// HI/LO register unit: MFHI/MFLO/MTHI/MTLO plus a 33-cycle restoring divider.
// Define HILO_MULT_EN to add a single-cycle MULT/MULTU into {HI,LO}.
module hilo_md_unit
    import hilo_md_pkg::*;
(
    input  logic             clk,
    input  logic             resetn,
    hilo_md_unit_if.slave    md
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] dvd_q, dvd_d;
    logic [31:0] dvs_q, dvs_d;
    logic [31:0] rem_q, rem_d;
    logic [31:0] quo_q, quo_d;
    logic        neg_quo_q, neg_quo_d;
    logic        neg_rem_q, neg_rem_d;
    logic        dvs_zero_q, dvs_zero_d;

    logic        accepted;
    logic        is_div;
    logic        start_div;
    logic        sign_a;
    logic        sign_b;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [32:0] rem_shift;
    logic [32:0] rem_diff;
    logic        step_ge;
    logic [31:0] rem_step;
    logic [31:0] quo_step;
    logic [31:0] quo_final;
    logic [31:0] rem_final;

`ifdef HILO_MULT_EN
    logic        mul_signed;
    logic [63:0] mul_a;
    logic [63:0] mul_b;
    logic [63:0] mul_prod;
`endif

    assign accepted  = md.validE && !md.flushE && (state_q == S_IDLE);
    assign is_div    = (md.alucontrolE == ALU_DIV) || (md.alucontrolE == ALU_DIVU);
    assign start_div = accepted && is_div;

    // Signed divide runs on magnitudes; the sign flags fix up the result at the end.
    always_comb begin
        sign_a = (md.alucontrolE == ALU_DIV) && md.srcaE[31];
        sign_b = (md.alucontrolE == ALU_DIV) && md.srcbE[31];
        mag_a  = sign_a ? (~md.srcaE + 32'd1) : md.srcaE;
        mag_b  = sign_b ? (~md.srcbE + 32'd1) : md.srcbE;
    end

    always_comb begin
        rem_shift = {rem_q, dvd_q[31]};
        rem_diff  = rem_shift - {1'b0, dvs_q};
        step_ge   = !rem_diff[32];
        rem_step  = step_ge ? rem_diff[31:0] : rem_shift[31:0];
        quo_step  = {quo_q[30:0], step_ge};
        quo_final = neg_quo_q ? (~quo_step + 32'd1) : quo_step;
        rem_final = neg_rem_q ? (~rem_step + 32'd1) : rem_step;
    end

`ifdef HILO_MULT_EN
    // Low 64 bits of the product of sign-extended operands equal the signed product.
    always_comb begin
        mul_signed = (md.alucontrolE == ALU_MULT);
        mul_a      = {{32{mul_signed && md.srcaE[31]}}, md.srcaE};
        mul_b      = {{32{mul_signed && md.srcbE[31]}}, md.srcbE};
        mul_prod   = mul_a * mul_b;
    end
`endif

    // State register
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q    <= S_IDLE;
            hi_q       <= 32'd0;
            lo_q       <= 32'd0;
            cnt_q      <= 5'd0;
            dvd_q      <= 32'd0;
            dvs_q      <= 32'd0;
            rem_q      <= 32'd0;
            quo_q      <= 32'd0;
            neg_quo_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            dvs_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            cnt_q      <= cnt_d;
            dvd_q      <= dvd_d;
            dvs_q      <= dvs_d;
            rem_q      <= rem_d;
            quo_q      <= quo_d;
            neg_quo_q  <= neg_quo_d;
            neg_rem_q  <= neg_rem_d;
            dvs_zero_q <= dvs_zero_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start_div) state_d = S_BUSY;
            end
            S_BUSY: begin
                if (md.flushE)           state_d = S_IDLE;
                else if (cnt_q == 5'd31) state_d = S_DONE;
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath: HI/LO writes and divider iteration
    always_comb begin
        hi_d       = hi_q;
        lo_d       = lo_q;
        cnt_d      = cnt_q;
        dvd_d      = dvd_q;
        dvs_d      = dvs_q;
        rem_d      = rem_q;
        quo_d      = quo_q;
        neg_quo_d  = neg_quo_q;
        neg_rem_d  = neg_rem_q;
        dvs_zero_d = dvs_zero_q;
        case (state_q)
            S_IDLE: begin
                if (accepted) begin
                    case (md.alucontrolE)
                        ALU_MTHI: hi_d = md.srcaE;
                        ALU_MTLO: lo_d = md.srcaE;
                        ALU_DIV, ALU_DIVU: begin
                            dvd_d      = mag_a;
                            dvs_d      = mag_b;
                            rem_d      = 32'd0;
                            quo_d      = 32'd0;
                            cnt_d      = 5'd0;
                            neg_quo_d  = sign_a ^ sign_b;
                            neg_rem_d  = sign_a;
                            dvs_zero_d = (md.srcbE == 32'd0);
                        end
`ifdef HILO_MULT_EN
                        ALU_MULT, ALU_MULTU: begin
                            hi_d = mul_prod[63:32];
                            lo_d = mul_prod[31:0];
                        end
`endif
                        default: ;
                    endcase
                end
            end
            S_BUSY: begin
                if (!md.flushE) begin
                    rem_d = rem_step;
                    quo_d = quo_step;
                    dvd_d = {dvd_q[30:0], 1'b0};
                    cnt_d = cnt_q + 5'd1;
                    // A zero divisor runs the full sequence but never commits.
                    if ((cnt_q == 5'd31) && !dvs_zero_q) begin
                        lo_d = quo_final;
                        hi_d = rem_final;
                    end
                end
            end
            default: ;
        endcase
    end

    // Outputs
    always_comb begin
        md.stallE = 1'b0;
        md.hiloE  = 32'd0;
        if (resetn) begin
            case (state_q)
                S_IDLE:  md.stallE = start_div;
                S_BUSY:  md.stallE = !md.flushE;
                default: md.stallE = 1'b0;
            endcase
            if (md.alucontrolE == ALU_MFHI)      md.hiloE = hi_q;
            else if (md.alucontrolE == ALU_MFLO) md.hiloE = lo_q;
        end
    end

    assign md.hi_o = hi_q;
    assign md.lo_o = lo_q;

endmodule
